message_sender: RTL and testbench
=================================

Name: message_sender

Overview:
- Sequencer that sits between the registered message ROM and the UART transmitter.
- On a trigger byte from the UART receiver, it walks ROM addresses 0..MSG_LEN-1.
- It accounts for the ROM's 1-cycle read latency and hands each byte to the transmitter using the transmitter's busy flag.
- It replaces ad-hoc top-level glue that drives the ROM address and UART tx strobe.

Parameters:
- MSG_LEN, 14, number of bytes sent per trigger (addresses 0..MSG_LEN-1); legal range 1..2^ADDR_W.
- ADDR_W, 4, width of the ROM address bus.
- TRIGGER_CHAR, 8'h68 ("h"), received byte value that starts a transmission.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  byte from UART receiver; valid only when new_rx_data=1.
- new_rx_data  in  1  single-cycle strobe marking rx_data valid.
- tx_busy  in  1  UART transmitter busy; rises the cycle after an accepted new_tx_data.
- rom_addr  out  ADDR_W  address to message ROM; ROM returns data registered one cycle later.
- rom_data  in  8  ROM output for the rom_addr presented on the previous cycle.
- tx_data  out  8  byte to transmitter; meaningful only while new_tx_data=1.
- new_tx_data  out  1  single-cycle send strobe to transmitter.
- active  out  1  high while a message is in progress (any state except IDLE).

Behaviour:
- State register: IDLE, FETCH, SEND. Index register addr_q of width ADDR_W; rom_addr = addr_q.
- Reset (rst=1 at clk edge): state=IDLE, addr_q=0.
  - Outputs from the next cycle: rom_addr=0, new_tx_data=0, active=0, tx_data=rom_data (don't-care).
  - Reset mid-message aborts immediately; no further new_tx_data pulses are issued.
- IDLE: if new_rx_data=1 and rx_data==TRIGGER_CHAR, set addr_q=0 and go to FETCH. Otherwise stay.
- FETCH: exactly one cycle, waiting for ROM latency, then go to SEND. No strobe is issued.
- SEND:
  - new_tx_data = (state==SEND) & ~tx_busy, combinational.
  - tx_data = rom_data, combinational pass-through.
  - If tx_busy=1, stay in SEND with addr_q held.
  - If tx_busy=0, the byte is issued this cycle:
    - if addr_q==MSG_LEN-1, set addr_q=0 and go to IDLE;
    - else increment addr_q and go to FETCH.
- The FETCH cycle after each send also covers the transmitter's 1-cycle busy-rise latency. SEND therefore never samples a stale tx_busy=0 from the previous byte.
- Minimum spacing between new_tx_data pulses is 2 cycles. In practice spacing is set by the UART frame time.
- Latency with tx idle: trigger strobe at cycle T; FETCH at T+1; first new_tx_data at T+2 carrying ROM byte 0.
- Triggers received while active=1 are ignored; they are not queued.
- Simultaneous events:
  - trigger and rst in the same cycle: rst wins, state=IDLE;
  - new_rx_data in the same cycle as the final send: ignored, since the FSM is not yet in IDLE.
- MSG_LEN=1: one FETCH/SEND pair per trigger.
- addr_q never exceeds MSG_LEN-1; no wrap beyond the ROM range.

Optional Feature:
- Macro: MESSAGE_SENDER_ECHO_EN.
- With it defined:
  - adds state ECHO and an 8-bit echo_q register (reset 0);
  - in IDLE, a new_rx_data byte not equal to TRIGGER_CHAR is captured into echo_q, and the FSM goes to ECHO;
  - in ECHO, new_tx_data = ~tx_busy and tx_data = echo_q; when issued, return to IDLE;
  - active=1 while in ECHO; bytes received during ECHO are dropped.
- Without it: non-trigger bytes are ignored, and no ECHO state or echo_q exists.

Test Plan:
- Reset then idle 20 cycles -> new_tx_data=0, rom_addr=0, active=0 throughout.
- Trigger 8'h68 with tx_busy held 0, ROM returning byte=addr+8'h41 -> new_tx_data pulses at T+2, T+4, ... T+28 carrying 8'h41..8'h4E. Exactly 14 pulses, then active=0.
- Transmitter model asserts busy for 10 cycles after each strobe -> exactly one pulse per busy-low window. Byte order 0..13 is preserved, and no pulse occurs while tx_busy=1.
- Second 8'h68 sent at byte 5 -> ignored; total pulses for the run = 14, and a trigger after completion starts a fresh 14.
- rst asserted during SEND at addr_q=7 -> no strobes after reset; rom_addr=0. A following trigger restarts at byte 0.
- ECHO_EN defined: receive 8'h41 in IDLE -> one new_tx_data with tx_data=8'h41, then active=0. ECHO_EN undefined: same stimulus -> no strobe.

Source files
------------

// File: rtl/message_sender.sv
// message_sender: sequencer between the registered message ROM and the UART
// transmitter. A trigger byte from the receiver starts a walk over ROM
// addresses 0..MSG_LEN-1. Each byte is handed to the transmitter once its
// busy flag is low.
// Optional feature: define MESSAGE_SENDER_ECHO_EN to echo any non-trigger
// byte received while idle back to the transmitter.
module message_sender #(
    parameter int          MSG_LEN      = 14,
    parameter int          ADDR_W       = 4,
    parameter logic [7:0]  TRIGGER_CHAR = 8'h68
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              new_rx_data,
    input  logic              tx_busy,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [7:0]        tx_data,
    output logic              new_tx_data,
    output logic              active
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MSG_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SEND  = 2'd2
`ifdef MESSAGE_SENDER_ECHO_EN
        ,
        S_ECHO  = 2'd3
`endif
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic                w_new_tx;
    logic [7:0]          w_tx_data;
    logic                w_trigger;

`ifdef MESSAGE_SENDER_ECHO_EN
    logic [7:0]          r_echo;
    logic [7:0]          w_echo_nxt;
`endif

    assign w_trigger = new_rx_data && (rx_data == TRIGGER_CHAR);

    // State, index and (optional) echo registers; reset aborts any message.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
`ifdef MESSAGE_SENDER_ECHO_EN
            r_echo  <= 8'h00;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
`ifdef MESSAGE_SENDER_ECHO_EN
            r_echo  <= w_echo_nxt;
`endif
        end
    end

    // Next-state and strobe logic. FETCH absorbs both the ROM read latency
    // and the transmitter's one-cycle busy-rise delay, so SEND never acts
    // on a stale busy-low left over from the previous byte.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_new_tx    = 1'b0;
        w_tx_data   = rom_data;
`ifdef MESSAGE_SENDER_ECHO_EN
        w_echo_nxt  = r_echo;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_trigger) begin
                    w_addr_nxt  = '0;
                    w_state_nxt = S_FETCH;
                end
`ifdef MESSAGE_SENDER_ECHO_EN
                else if (new_rx_data) begin
                    w_echo_nxt  = rx_data;
                    w_state_nxt = S_ECHO;
                end
`endif
            end
            S_FETCH: begin
                w_state_nxt = S_SEND;
            end
            S_SEND: begin
                w_new_tx = ~tx_busy;
                if (!tx_busy) begin
                    if (r_addr == LAST_ADDR) begin
                        w_addr_nxt  = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_addr_nxt  = r_addr + ADDR_W'(1);
                        w_state_nxt = S_FETCH;
                    end
                end
            end
`ifdef MESSAGE_SENDER_ECHO_EN
            S_ECHO: begin
                w_new_tx  = ~tx_busy;
                w_tx_data = r_echo;
                if (!tx_busy) begin
                    w_state_nxt = S_IDLE;
                end
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign rom_addr    = r_addr;
    assign tx_data     = w_tx_data;
    assign new_tx_data = w_new_tx;
    assign active      = (r_state != S_IDLE);

endmodule

// File: tb/tb_message_sender.sv
// Testbench for message_sender: registered ROM model (byte = addr + 8'h41)
// and a transmitter model that holds busy for busy_len cycles per strobe.
module tb_message_sender;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       new_rx_data = 1'b0;
    logic       tx_busy;
    logic [3:0] rom_addr;
    logic [7:0] rom_data = 8'h00;
    logic [7:0] tx_data;
    logic       new_tx_data;
    logic       active;

    int n_pass = 0;
    int n_tot  = 0;
    int cyc    = 0;
    int busy_len = 0;
    int busy_cnt = 0;
    int viol   = 0;
    logic [7:0] byte_q[$];
    int         cyc_q[$];

    message_sender #(.MSG_LEN(14), .ADDR_W(4), .TRIGGER_CHAR(8'h68)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .new_rx_data(new_rx_data),
        .tx_busy(tx_busy), .rom_addr(rom_addr), .rom_data(rom_data),
        .tx_data(tx_data), .new_tx_data(new_tx_data), .active(active)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Registered ROM: data for the address presented last cycle.
    always @(posedge clk) rom_data <= {4'h0, rom_addr} + 8'h41;

    // Transmitter: busy rises the cycle after an accepted strobe.
    always @(posedge clk) begin
        if (new_tx_data && busy_len > 0) busy_cnt <= busy_len;
        else if (busy_cnt > 0)           busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    // Record every strobe and flag any strobe issued while busy.
    always @(negedge clk) begin
        if (new_tx_data) begin
            byte_q.push_back(tx_data);
            cyc_q.push_back(cyc);
            if (tx_busy) viol <= viol + 1;
        end
    end

    typedef struct {
        int busy_len;
        int inject_at;     // pulse count at which a second trigger arrives, -1 none
        int exp_spacing;   // cycles between consecutive strobes
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input int act, input int exp);
        n_tot++;
        if (act != exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, output int tc);
        rx_data     = b;
        new_rx_data = 1'b1;
        tc          = cyc;
        tick();
        new_rx_data = 1'b0;
    endtask

    task automatic run_case(input int idx, input vec_t v);
        int base, vbase, t0, n, waited;
        bit injected, done, order_ok, spacing_ok;
        string tag;
        tag       = $sformatf("case%0d", idx);
        busy_len  = v.busy_len;
        base      = byte_q.size();
        vbase     = viol;
        injected  = 0;
        done      = 0;
        waited    = 0;
        send_byte(8'h68, t0);
        while (!done && waited < 2000) begin
            if (!injected && v.inject_at >= 0 && (byte_q.size() - base) == v.inject_at) begin
                rx_data     = 8'h68;
                new_rx_data = 1'b1;
                injected    = 1;
            end
            tick();
            new_rx_data = 1'b0;
            waited++;
            if (!active) done = 1;
        end
        chk({tag, "_complete"}, int'(done), 1);
        repeat (20) tick();
        n = byte_q.size() - base;
        chk({tag, "_pulses"}, n, 14);
        order_ok = (n == 14);
        for (int i = 0; i < n; i++)
            if (byte_q[base+i] != 8'(8'h41 + i)) order_ok = 0;
        chk({tag, "_order"}, int'(order_ok), 1);
        chk({tag, "_first_lat"}, (n > 0) ? cyc_q[base] - t0 : -1, 2);
        spacing_ok = 1;
        for (int i = 1; i < n; i++)
            if (cyc_q[base+i] - cyc_q[base+i-1] != v.exp_spacing) spacing_ok = 0;
        chk({tag, "_spacing"}, int'(spacing_ok), 1);
        chk({tag, "_busy_viol"}, viol - vbase, 0);
        chk({tag, "_active_end"}, int'(active), 0);
        chk({tag, "_addr_end"}, int'(rom_addr), 0);
    endtask

    initial begin
        int base, t0, n, waited;
        bit any_bad;

        vecs[0] = '{busy_len: 0,  inject_at: -1, exp_spacing: 2};
        vecs[1] = '{busy_len: 10, inject_at: -1, exp_spacing: 11};
        vecs[2] = '{busy_len: 0,  inject_at: 5,  exp_spacing: 2};
        vecs[3] = '{busy_len: 3,  inject_at: 5,  exp_spacing: 4};
        vecs[4] = '{busy_len: 1,  inject_at: -1, exp_spacing: 2};

        // Reset, then 20 idle cycles.
        repeat (3) tick();
        rst = 1'b0;
        base    = byte_q.size();
        any_bad = 0;
        repeat (20) begin
            tick();
            if (active || rom_addr != 4'd0) any_bad = 1;
        end
        chk("idle_pulses", byte_q.size() - base, 0);
        chk("idle_addr_active", int'(any_bad), 0);
        chk("idle_active", int'(active), 0);

        for (int i = 0; i < 5; i++) run_case(i, vecs[i]);

        // Reset while waiting in SEND at address 7.
        busy_len = 10;
        base = byte_q.size();
        send_byte(8'h68, t0);
        waited = 0;
        while (!((byte_q.size() - base) == 7 && rom_addr == 4'd7) && waited < 500) begin
            tick();
            waited++;
        end
        chk("rst_reach_addr7", int'(rom_addr), 7);
        tick();
        chk("rst_pre_active", int'(active), 1);
        chk("rst_pre_held", int'(new_tx_data), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_addr", int'(rom_addr), 0);
        chk("rst_active", int'(active), 0);
        repeat (30) tick();
        chk("rst_no_more_pulses", byte_q.size() - base, 7);
        run_case(5, vecs[1]);

        // Trigger together with reset: reset wins.
        busy_len    = 0;
        base        = byte_q.size();
        rx_data     = 8'h68;
        new_rx_data = 1'b1;
        rst         = 1'b1;
        tick();
        new_rx_data = 1'b0;
        rst         = 1'b0;
        chk("rst_trig_active", int'(active), 0);
        repeat (5) tick();
        chk("rst_trig_pulses", byte_q.size() - base, 0);

        // Non-trigger byte while idle.
        base = byte_q.size();
        send_byte(8'h41, t0);
        repeat (10) tick();
        n = byte_q.size() - base;
`ifdef MESSAGE_SENDER_ECHO_EN
        chk("echo_pulses", n, 1);
        chk("echo_data", (n >= 1) ? int'(byte_q[base]) : -1, 8'h41);
        chk("echo_lat", (n >= 1) ? cyc_q[base] - t0 : -1, 1);
`else
        chk("noecho_pulses", n, 0);
`endif
        chk("echo_active_end", int'(active), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
